// File: rtl/cnn_window_feeder.sv
// Loads a 28x28 byte image, pulses START, then presents every 5x5 window (one per cycle) and captures the CNN class.
// Optional DONE watchdog is compiled in with `define CNN_FEEDER_TIMEOUT_EN.
module cnn_window_feeder #(
    parameter int IMG_DIM     = 28,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic         PIX_VALID,
    input  logic [7:0]   PIX_DATA,
    output logic         PIX_READY,
    output logic         START,
    output logic [4:0]   X,
    output logic [4:0]   Y,
    output logic [199:0] IMGIN,
    output logic         WIN_VALID,
    input  logic         CNN_DONE,
    input  logic [3:0]   CNN_OUT,
    output logic         RES_VALID,
    output logic [3:0]   RES_CLASS,
    output logic [6:0]   RES_IDX,
    output logic         ERR,
    output logic [2:0]   DBG_STATE
);
    localparam int         NPIX     = IMG_DIM * IMG_DIM;
    localparam logic [4:0] LAST     = 5'(IMG_DIM - 5);
    localparam logic [9:0] LAST_PIX = 10'(NPIX - 1);
    localparam logic [9:0] DIM10    = 10'(IMG_DIM);

    typedef enum logic [2:0] {S_LOAD, S_STRT, S_STREAM, S_WAIT, S_RESULT} state_t;
    state_t state_q, state_d;

    logic [7:0]   mem [NPIX];
    logic [9:0]   pix_cnt_q;
    logic [4:0]   x_q, y_q, nx, ny;
    logic [199:0] imgin_q, win_next;
    logic         win_valid_q;
    logic [3:0]   res_class_q;
    logic [6:0]   res_idx_q;
    logic         pix_acc, last_win, tmo_hit;

    assign pix_acc  = (state_q == S_LOAD) && PIX_VALID;
    assign last_win = (x_q == LAST) && (y_q == LAST);

`ifdef CNN_FEEDER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    logic [TW-1:0] tmo_q;
    logic          err_q;
    // DONE has priority over an expiring watchdog in the same cycle.
    assign tmo_hit = (state_q == S_WAIT) && !CNN_DONE && (tmo_q == TW'(TIMEOUT_CYC - 1));
    assign ERR     = err_q && (state_q == S_RESULT);
`else
    assign tmo_hit = 1'b0;
    assign ERR     = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if (RST) state_q <= S_LOAD;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_LOAD:   if (pix_acc && pix_cnt_q == LAST_PIX) state_d = S_STRT;
            S_STRT:   state_d = S_STREAM;
            S_STREAM: if (last_win) state_d = S_WAIT;
            S_WAIT:   if (CNN_DONE || tmo_hit) state_d = S_RESULT;
            S_RESULT: state_d = S_LOAD;
            default:  state_d = S_LOAD;
        endcase
    end

    // Coordinates of the window registered at the next edge (Y inner, X outer).
    always_comb begin
        nx = '0;
        ny = '0;
        if (state_q == S_STREAM && !last_win) begin
            if (y_q == LAST) begin
                nx = x_q + 5'd1;
                ny = '0;
            end else begin
                nx = x_q;
                ny = y_q + 5'd1;
            end
        end
    end

    always_comb begin
        logic [9:0] row;
        logic [9:0] addr;
        row      = '0;
        addr     = '0;
        win_next = '0;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < 5; j++) begin
                row  = {5'd0, nx} + 10'(i);
                addr = row * DIM10 + {5'd0, ny} + 10'(j);
                win_next[8*(i*5+j) +: 8] = mem[addr];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (pix_acc) mem[pix_cnt_q] <= PIX_DATA;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            pix_cnt_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            imgin_q     <= '0;
            win_valid_q <= 1'b0;
            res_class_q <= '0;
            res_idx_q   <= '0;
`ifdef CNN_FEEDER_TIMEOUT_EN
            tmo_q       <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                S_LOAD: if (pix_acc) pix_cnt_q <= pix_cnt_q + 10'd1;
                S_STRT, S_STREAM: begin
                    if (state_q == S_STREAM && last_win) begin
                        win_valid_q <= 1'b0;
                        x_q         <= '0;
                        y_q         <= '0;
                        imgin_q     <= '0;
`ifdef CNN_FEEDER_TIMEOUT_EN
                        tmo_q       <= '0;
`endif
                    end else begin
                        win_valid_q <= 1'b1;
                        x_q         <= nx;
                        y_q         <= ny;
                        imgin_q     <= win_next;
                    end
                end
                S_WAIT: begin
                    if (CNN_DONE) begin
                        res_class_q <= CNN_OUT;
`ifdef CNN_FEEDER_TIMEOUT_EN
                        err_q       <= 1'b0;
                    end else if (tmo_hit) begin
                        res_class_q <= 4'hF;
                        err_q       <= 1'b1;
                    end else begin
                        tmo_q       <= tmo_q + TW'(1);
`endif
                    end
                end
                S_RESULT: begin
                    res_idx_q <= res_idx_q + 7'd1;
                    pix_cnt_q <= '0;
`ifdef CNN_FEEDER_TIMEOUT_EN
                    err_q     <= 1'b0;
`endif
                end
                default: ;
            endcase
        end
    end

    assign PIX_READY = (state_q == S_LOAD);
    assign START     = (state_q == S_STRT);
    assign RES_VALID = (state_q == S_RESULT);
    assign WIN_VALID = win_valid_q;
    assign X         = x_q;
    assign Y         = y_q;
    assign IMGIN     = imgin_q;
    assign RES_CLASS = res_class_q;
    assign RES_IDX   = res_idx_q;
    assign DBG_STATE = state_q;
endmodule

// File: tb/tb_cnn_window_feeder.sv
// Bench for cnn_window_feeder: scoreboard of expected windows/results, spot-value table, reset and DONE corner cases.
module tb_cnn_window_feeder;
    logic         CLK = 1'b0;
    logic         RST = 1'b1;
    logic         PIX_VALID = 1'b0;
    logic [7:0]   PIX_DATA = '0;
    logic         PIX_READY, START, WIN_VALID, RES_VALID, ERR;
    logic [4:0]   X, Y;
    logic [199:0] IMGIN;
    logic         CNN_DONE = 1'b0;
    logic [3:0]   CNN_OUT = '0;
    logic [3:0]   RES_CLASS;
    logic [6:0]   RES_IDX;
    logic [2:0]   DBG_STATE;

    always #5 CLK = ~CLK;

    cnn_window_feeder #(.IMG_DIM(28), .TIMEOUT_CYC(16)) dut (
        .CLK(CLK), .RST(RST), .PIX_VALID(PIX_VALID), .PIX_DATA(PIX_DATA),
        .PIX_READY(PIX_READY), .START(START), .X(X), .Y(Y), .IMGIN(IMGIN),
        .WIN_VALID(WIN_VALID), .CNN_DONE(CNN_DONE), .CNN_OUT(CNN_OUT),
        .RES_VALID(RES_VALID), .RES_CLASS(RES_CLASS), .RES_IDX(RES_IDX),
        .ERR(ERR), .DBG_STATE(DBG_STATE)
    );

    int tests_run = 0;
    int tests_failed = 0;
    int win_cnt = 0;
    int res_cnt = 0;
    logic [209:0] exp_q[$];   // {X, Y, IMGIN}
    logic [11:0]  res_q[$];   // {ERR, RES_CLASS, RES_IDX}
    logic [7:0]   img [784];
    logic [199:0] win_seen [24][24];

    typedef struct {
        int         x;
        int         y;
        int         b;
        logic [7:0] v;
    } spot_t;
    spot_t spots[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [199:0] model_win(input int x, input int y);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[8*(i*5+j) +: 8] = img[(x+i)*28 + (y+j)];
        return w;
    endfunction

    // Outputs are compared on the falling edge, well away from the active edge.
    always @(negedge CLK) begin : mon
        logic [209:0] e;
        logic [11:0]  r;
        if (WIN_VALID === 1'b1) begin
            win_cnt++;
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL window_unexpected: got X=%0d Y=%0d, expected no window", X, Y);
            end else begin
                e = exp_q.pop_front();
                if ({X, Y, IMGIN} !== e) begin
                    tests_failed++;
                    $display("FAIL window: got X=%0d Y=%0d IMGIN=%h expected X=%0d Y=%0d IMGIN=%h",
                             X, Y, IMGIN, e[209:205], e[204:200], e[199:0]);
                end
            end
            if (X < 24 && Y < 24) win_seen[X][Y] = IMGIN;
        end
        if (RES_VALID === 1'b1) begin
            res_cnt++;
            tests_run++;
            if (res_q.size() == 0) begin
                tests_failed++;
                $display("FAIL result_unexpected: got class=%0h idx=%0d, expected no result", RES_CLASS, RES_IDX);
            end else begin
                r = res_q.pop_front();
                if ({ERR, RES_CLASS, RES_IDX} !== r) begin
                    tests_failed++;
                    $display("FAIL result: got err=%0b class=%0h idx=%0d expected err=%0b class=%0h idx=%0d",
                             ERR, RES_CLASS, RES_IDX, r[11], r[10:7], r[6:0]);
                end
            end
        end
    end

    task automatic load_image(input bit gapped);
        int cnt;
        int p;
        bit on;
        bit rdy;
        cnt = 0;
        p = 0;
        while (cnt < 784 && p < 4000) begin
            on = !gapped || (p % 3 == 0);
            PIX_VALID = on;
            PIX_DATA = on ? img[cnt] : 8'($urandom_range(0, 255));
            rdy = PIX_READY;
            tick();
            if (on && rdy) cnt++;
            p++;
        end
        PIX_VALID = 1'b0;
        check("load_count", cnt, 784);
        for (int x = 0; x < 24; x++)
            for (int y = 0; y < 24; y++)
                exp_q.push_back({5'(x), 5'(y), model_win(x, y)});
        check("start_after_last_pixel", START, 1);
        check("pix_ready_dropped", PIX_READY, 0);
    endtask

    task automatic wait_stream_end();
        int n;
        n = 0;
        while (WIN_VALID === 1'b1 && n < 800) begin
            tick();
            n++;
        end
        check("stream_end_in_budget", (n < 800), 1);
        check("exp_queue_drained", exp_q.size(), 0);
        check("xy_cleared_after_stream", {X, Y}, 0);
        check("wait_state", DBG_STATE, 3);
    endtask

    task automatic finish_result(input logic [3:0] cls, input logic [6:0] idx);
        res_q.push_back({1'b0, cls, idx});
        CNN_OUT = cls;
        CNN_DONE = 1'b1;
        tick();
        CNN_DONE = 1'b0;
        CNN_OUT = 4'd0;
        tick();
        check("result_queue_drained", res_q.size(), 0);
        check("res_class_held", RES_CLASS, cls);
        check("res_idx_incremented", RES_IDX, 7'(idx + 7'd1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int rc;
        logic [3:0] cls;
        spots[0] = '{0, 0, 0, 8'h00};
        spots[1] = '{0, 0, 4, 8'h04};
        spots[2] = '{0, 0, 5, 8'h1C};
        spots[3] = '{0, 0, 24, 8'h74};
        spots[4] = '{23, 23, 0, 8'h9B};
        spots[5] = '{23, 23, 24, 8'h0F};
        spots[6] = '{0, 23, 4, 8'h1B};
        spots[7] = '{10, 5, 12, 8'h57};

        repeat (3) tick();
        RST = 1'b0;
        check("rst_pix_ready", PIX_READY, 1);
        check("rst_start", START, 0);
        check("rst_win_valid", WIN_VALID, 0);
        check("rst_res_valid", RES_VALID, 0);
        check("rst_xy", {X, Y}, 0);
        check("rst_imgin_low", IMGIN[31:0], 0);
        check("rst_res_idx", RES_IDX, 0);
        check("rst_err", ERR, 0);

        // Image 1: ramp, continuous stream, DONE noise during STREAM.
        for (int k = 0; k < 784; k++) img[k] = 8'(k);
        win_cnt = 0;
        load_image(1'b0);
        tick();
        check("start_one_cycle", START, 0);
        CNN_DONE = 1'b1;
        CNN_OUT = 4'd3;
        repeat (20) tick();
        CNN_DONE = 1'b0;
        CNN_OUT = 4'd0;
        wait_stream_end();
        check("window_count", win_cnt, 576);
        for (int s = 0; s < 8; s++)
            check($sformatf("spot_%0d_%0d_b%0d", spots[s].x, spots[s].y, spots[s].b),
                  win_seen[spots[s].x][spots[s].y][8*spots[s].b +: 8], spots[s].v);
        rc = res_cnt;
        repeat (10) tick();
        check("no_result_before_done", res_cnt, rc);
        finish_result(4'd7, 7'd0);
        check("single_result", res_cnt, rc + 1);

        // Image 2: random pixels, 1-on/2-off valid pattern.
        for (int k = 0; k < 784; k++) img[k] = 8'($urandom_range(0, 255));
        win_cnt = 0;
        load_image(1'b1);
        tick();
        wait_stream_end();
        check("window_count_gapped", win_cnt, 576);
        cls = 4'($urandom_range(0, 14));
        repeat ($urandom_range(0, 5)) tick();
        finish_result(cls, 7'd1);

        // Image 3: reset at window (10,5).
        for (int k = 0; k < 784; k++) img[k] = ~8'(k);
        load_image(1'b0);
        n = 0;
        while (!(WIN_VALID === 1'b1 && X == 5'd10 && Y == 5'd5) && n < 800) begin
            tick();
            n++;
        end
        check("reached_window_10_5", (n < 800), 1);
        rc = res_cnt;
        RST = 1'b1;
        tick();
        check("rst_mid_win_valid", WIN_VALID, 0);
        RST = 1'b0;
        exp_q.delete();
        tick();
        check("rst_mid_pix_ready", PIX_READY, 1);
        check("rst_mid_res_idx", RES_IDX, 0);
        CNN_DONE = 1'b1;
        tick();
        CNN_DONE = 1'b0;
        repeat (30) tick();
        check("rst_mid_no_result", res_cnt, rc);
        check("rst_mid_state_load", DBG_STATE, 0);

        // Image 4: recovery after reset; watchdog path when compiled in.
        for (int k = 0; k < 784; k++) img[k] = 8'(k * 3 + 1);
        load_image(1'b0);
        tick();
        wait_stream_end();
`ifdef CNN_FEEDER_TIMEOUT_EN
        res_q.push_back({1'b1, 4'hF, 7'd0});
        n = 0;
        while (RES_VALID !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        check("timeout_latency", n, 16);
        check("timeout_err", ERR, 1);
        tick();
        tick();
        check("timeout_result_drained", res_q.size(), 0);
        check("timeout_err_cleared", ERR, 0);
        check("timeout_idx", RES_IDX, 1);
`else
        repeat (40) tick();
        check("no_timeout_when_absent", DBG_STATE, 3);
        finish_result(4'd2, 7'd0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
